// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: ALU results take priority over a DEPTH-entry load FIFO.
// Build option WB_LOAD_PRIO_EN: a full load FIFO stalls the ALU and forces a drain.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            wr_en,
  input  logic [4:0]      q_addr,
  output logic            q_hit
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t         fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic            full, empty;
  logic            alu_fire, alu_sel, mem_fire, push, pop;
  logic [DEPTH-1:0] ent_vld;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef WB_LOAD_PRIO_EN
  assign alu_ready = ~full;
`else
  assign alu_ready = 1'b1;
`endif
  assign mem_ready = ~full;

  assign alu_fire = alu_valid & alu_ready;
  assign alu_sel  = alu_fire & (alu_rd != 5'd0);
  assign mem_fire = mem_valid & mem_ready;
  // Loads to x0 are dropped at the door so they never occupy a slot.
  assign push     = mem_fire & (mem_rd != 5'd0);
  assign pop      = ~alu_sel & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{rd: mem_rd, data: mem_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (alu_sel) begin
      wr_en   <= 1'b1;
      wr_addr <= alu_rd;
      wr_data <= alu_data;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_addr <= fifo[rd_ptr].rd;
      wr_data <= fifo[rd_ptr].data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [AW-1:0] off;
    assign off        = AW'(g) - rd_ptr;
    assign ent_vld[g] = ({1'b0, off} < count);
  end

  always_comb begin
    q_hit = wr_en && (wr_addr == q_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (q_addr != 5'd0) && (fifo[i].rd == q_addr)) q_hit = 1'b1;
    end
  end
endmodule
